// File: rtl/chan_mux_pkg.sv
// rtl/chan_mux_pkg.sv - shared constants for the channel mux with scan mode
// Holds the FSM state encoding and the mode input encoding used by
// chan_mux_scan and its dwell counter.
package chan_mux_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_MANUAL = 2'd1;
    localparam state_t ST_SCAN   = 2'd2;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_mux_scan_dwell_counter.sv
// rtl/chan_mux_scan_dwell_counter.sv - dwell counter pacing the scan channel steps
// Counts cycles while en is high and raises tick (combinationally) on the
// cycle the count sits at DWELL-1; the count reloads to 0 on that same edge.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, count -> 0
//   clr   synchronous clear, count -> 0 (has priority over en)
//   en    advance the count this cycle
//   tick  high when en is set and the count is at DWELL-1
module dwell_counter
    import chan_mux_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // DWELL=1 still needs a 1-bit register; with LAST=0 it ticks every enabled cycle.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chan_mux_scan.sv
// rtl/chan_mux_scan.sv - registered N-channel mux with manual select and auto scan
// Optional feature macro: MUX_HOLD_EN (IDLE holds y and cur_ch instead of clearing).
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   enable   0 forces IDLE
//   mode     0 = manual select, 1 = auto scan
//   sel      channel index used in manual mode
//   din      packed inputs, channel k at din[k*WIDTH +: WIDTH]
//   y        registered selected data
//   y_valid  y carries valid channel data
//   cur_ch   channel index currently driving y
//   wrap     one-cycle pulse on the scan step from CHANNELS-1 back to 0
module chan_mux_scan
    import chan_mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    output logic [SEL_W-1:0]          cur_ch,
    output logic                      wrap
);

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic             y_valid_q;
    logic             y_valid_d;
    logic [SEL_W-1:0] cur_ch_q;
    logic [SEL_W-1:0] cur_ch_d;
    logic             wrap_q;
    logic             wrap_d;

    logic scan_run;
    logic tick;
    logic sel_in_range;

    // Out-of-range indices (non-power-of-2 CHANNELS) select zero instead of
    // reading past the end of din.
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0]          idx);
        logic [WIDTH-1:0] res;
        res = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                res = bus[k*WIDTH +: WIDTH];
            end
        end
        return res;
    endfunction

    // Scan continues only when already scanning and staying in scan; any other
    // path into SCAN is an entry and restarts at channel 0 with a cleared count.
    assign scan_run     = (state_q == ST_SCAN) && (state_d == ST_SCAN);
    assign sel_in_range = {1'b0, sel} < CH_LIMIT;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (!scan_run),
        .en   (scan_run),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if (enable) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        end
    end

    // Outputs are computed for the state being entered so that inputs sampled
    // at an edge appear on y/y_valid/cur_ch right after that edge.
    always_comb begin
        y_d       = y_q;
        y_valid_d = 1'b0;
        cur_ch_d  = cur_ch_q;
        wrap_d    = 1'b0;
        case (state_d)
            ST_MANUAL: begin
                cur_ch_d = sel;
                if (sel_in_range) begin
                    y_d       = pick(din, sel);
                    y_valid_d = 1'b1;
                end else begin
                    y_d = '0;
                end
            end
            ST_SCAN: begin
                if (!scan_run) begin
                    cur_ch_d = '0;
                end else if (tick) begin
                    if (cur_ch_q == LAST_CH) begin
                        cur_ch_d = '0;
                        wrap_d   = 1'b1;
                    end else begin
                        cur_ch_d = cur_ch_q + 1'b1;
                    end
                end
                // y follows the live din slice of the channel being driven.
                y_d       = pick(din, cur_ch_d);
                y_valid_d = 1'b1;
            end
            default: begin
`ifdef MUX_HOLD_EN
                y_d      = y_q;
                cur_ch_d = cur_ch_q;
`else
                y_d      = '0;
                cur_ch_d = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            cur_ch_q  <= '0;
            wrap_q    <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            cur_ch_q  <= cur_ch_d;
            wrap_q    <= wrap_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign cur_ch  = cur_ch_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_chan_mux_scan.sv
// tb/tb_chan_mux_scan.sv - randomized model-checked bench for chan_mux_scan
// Two instances: A (CHANNELS=4, DWELL=4) and B (CHANNELS=3, DWELL=1), fed the
// same controls; B sees the low three channels of A's din.
module tb_chan_mux_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] din4;
    logic [23:0] din3;

    logic [7:0]  y_a, y_b;
    logic        yv_a, yv_b;
    logic [1:0]  ch_a, ch_b;
    logic        wr_a, wr_b;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance: 0 idle, 1 manual, 2 scan.
    int          m_st [2];
    int          m_e  [2];
    logic [7:0]  m_y  [2];
    logic        m_v  [2];
    logic [1:0]  m_ch [2];
    logic        m_w  [2];
    int          nch  [2] = '{4, 3};
    int          dw   [2] = '{4, 1};

    always #5 clk = ~clk;

    chan_mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) u_a (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel(sel), .din(din4),
        .y(y_a), .y_valid(yv_a), .cur_ch(ch_a), .wrap(wr_a)
    );

    chan_mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel(sel), .din(din3),
        .y(y_b), .y_valid(yv_b), .cur_ch(ch_b), .wrap(wr_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] slice(input int d, input int ch);
        logic [31:0] v;
        v = (d == 0) ? din4 : {8'h00, din3};
        return v[ch*8 +: 8];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_e[d] = 0; m_y[d] = '0; m_v[d] = 1'b0; m_ch[d] = '0; m_w[d] = 1'b0;
        end
    endtask

    // Scan position is derived from cycles elapsed since scan entry.
    task automatic model_step(input int d);
        if (!enable) begin
            m_st[d] = 0; m_e[d] = 0; m_v[d] = 1'b0; m_w[d] = 1'b0;
`ifndef MUX_HOLD_EN
            m_y[d] = '0; m_ch[d] = '0;
`endif
        end else if (!mode) begin
            m_st[d] = 1; m_e[d] = 0; m_ch[d] = sel; m_w[d] = 1'b0;
            if (int'(sel) < nch[d]) begin
                m_y[d] = slice(d, int'(sel)); m_v[d] = 1'b1;
            end else begin
                m_y[d] = '0; m_v[d] = 1'b0;
            end
        end else begin
            if (m_st[d] != 2) m_e[d] = 0;
            else m_e[d] = m_e[d] + 1;
            m_st[d] = 2;
            m_ch[d] = 2'((m_e[d] / dw[d]) % nch[d]);
            m_w[d]  = (m_e[d] > 0) && (m_e[d] % (dw[d] * nch[d]) == 0);
            m_y[d]  = slice(d, int'(m_ch[d]));
            m_v[d]  = 1'b1;
        end
    endtask

    task automatic check_all();
        check_eq("a_y", y_a, m_y[0]);
        check_eq("a_valid", yv_a, m_v[0]);
        check_eq("a_cur_ch", ch_a, m_ch[0]);
        check_eq("a_wrap", wr_a, m_w[0]);
        check_eq("b_y", y_b, m_y[1]);
        check_eq("b_valid", yv_b, m_v[1]);
        check_eq("b_cur_ch", ch_b, m_ch[1]);
        check_eq("b_wrap", wr_b, m_w[1]);
    endtask

    task automatic step();
        din3 = din4[23:0];
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 1'b0; sel = '0; din4 = '0; din3 = '0;
        model_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_eq("rst_y", y_a, 0);
        check_eq("rst_valid", yv_a, 0);
        check_eq("rst_cur_ch", ch_a, 0);
        check_eq("rst_wrap", wr_a, 0);
        rst = 1'b0;

        // Manual select
        din4 = 32'hDDCCBBAA; enable = 1'b1; mode = 1'b0; sel = 2'd2;
        step();
        check_eq("man_sel2", y_a, 8'hCC);
        sel = 2'd0;
        step();
        check_eq("man_sel0", y_a, 8'hAA);

        // Scan 20 cycles with live-changing din
        mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din4 = $urandom;
            step();
            if (i == 16) check_eq("scan_wrap16", wr_a, 1);
        end

        // Disable at channel 1, then re-enable
        din4 = 32'hDDCCBBAA;
        step();
        check_eq("dis_pre_ch", ch_a, 1);
        enable = 1'b0;
        step();
`ifdef MUX_HOLD_EN
        check_eq("dis_y_hold", y_a, 8'hBB);
`else
        check_eq("dis_y", y_a, 0);
`endif
        check_eq("dis_valid", yv_a, 0);
        enable = 1'b1;
        step();
        check_eq("reen_ch", ch_a, 0);

        // Mode switch at channel 3, dwell count 2
        for (int i = 0; i < 14; i++) begin
            din4 = $urandom;
            step();
        end
        check_eq("ms_pre_ch", ch_a, 3);
        din4 = 32'hDDCCBBAA; mode = 1'b0; sel = 2'd1;
        step();
        check_eq("ms_y", y_a, 8'hBB);
        check_eq("ms_wrap", wr_a, 0);
        mode = 1'b1;
        step();
        check_eq("ms_back_ch", ch_a, 0);

        // Asynchronous reset mid-scan at channel 2
        for (int i = 0; i < 8; i++) begin
            din4 = $urandom;
            step();
        end
        check_eq("ar_pre_ch", ch_a, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_y", y_a, 0);
        check_eq("ar_valid", yv_a, 0);
        check_eq("ar_cur_ch", ch_a, 0);
        check_eq("ar_wrap", wr_a, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Out-of-range manual select on the 3-channel instance
        enable = 1'b1; mode = 1'b0; sel = 2'd3; din4 = $urandom;
        step();
        check_eq("oor_y", y_b, 0);
        check_eq("oor_valid", yv_b, 0);
        check_eq("oor_cur_ch", ch_b, 3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) mode = ~mode;
            sel  = 2'($urandom);
            din4 = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chan_mux_scan.md
Name: chan_mux_scan

Overview:
Parametrised, registered N-channel, W-bit multiplexer with enable. It generalises the team's single-bit enable/select mux. Adds a scan mode that auto-steps through channels on a programmable dwell count. Sits between parallel data sources and a single shared output bus; registered output with a valid flag.

Parameters:
WIDTH, 8, data width per channel
CHANNELS, 4, number of input channels (>=2)
DWELL, 4, cycles each channel is held in scan mode (>=1)
SEL_W, $clog2(CHANNELS), select/channel index width (derived, localparam)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
enable  in  1  block enable; 0 forces IDLE
mode  in  1  0 = manual select, 1 = auto scan
sel  in  SEL_W  channel index used in manual mode
din  in  CHANNELS*WIDTH  packed inputs, channel k at din[k*WIDTH +: WIDTH]
y  out  WIDTH  registered selected data
y_valid  out  1  y holds valid channel data this cycle
cur_ch  out  SEL_W  channel index currently driving y
wrap  out  1  one-cycle pulse when scan steps from CHANNELS-1 to 0

Behaviour:
- Reset (async, rst=1): state=IDLE, y=0, y_valid=0, cur_ch=0, wrap=0, dwell counter=0. Reset mid-operation aborts immediately; no output glitch after release beyond reset values.
- States: IDLE, MANUAL, SCAN. Next state is registered each clk.
  - enable=0 -> IDLE from any state.
  - enable=1 & mode=0 -> MANUAL.
  - enable=1 & mode=1 -> SCAN.
- Latency: 1 cycle. Inputs sampled at edge n appear on y/y_valid/cur_ch after edge n.
- IDLE: y=0, y_valid=0, wrap=0. cur_ch and dwell counter reset to 0.
- MANUAL: cur_ch<=sel, y<=din[sel], y_valid=1.
  - sel >= CHANNELS (non-power-of-2 CHANNELS): y<=0, y_valid<=0, cur_ch<=sel.
- SCAN entry (from IDLE or MANUAL): first cycle outputs channel 0, dwell counter=0.
- SCAN operation:
  - Counter increments each cycle.
  - When counter==DWELL-1: counter<=0, cur_ch<=cur_ch+1.
  - If cur_ch==CHANNELS-1, it instead wraps to 0 and asserts wrap for that one cycle (coincident with the first cycle of channel 0 on y).
  - y tracks din[cur_ch] live every cycle, not latched at channel entry. y_valid=1.
- DWELL=1: channel advances every cycle; wrap every CHANNELS cycles.
- Mode change mid-dwell (SCAN->MANUAL): takes effect next cycle, counter cleared. Returning to SCAN restarts at channel 0.
- enable deasserted for one cycle in SCAN: scan restarts at channel 0 (no resume).
- wrap is never asserted outside SCAN.

Optional Feature:
- Macro MUX_HOLD_EN.
- Defined: in IDLE, y holds its last value instead of clearing to 0; y_valid still 0; cur_ch holds.
- Undefined: IDLE drives y=0 and cur_ch=0 as above.
- Reset behaviour is identical either way.

Decomposition:
- Shared package chan_mux_pkg: state encoding localparams (ST_IDLE=2'd0, ST_MANUAL=2'd1, ST_SCAN=2'd2) and mode constants (MODE_MANUAL=1'b0, MODE_SCAN=1'b1).
- One sub-module, dwell_counter (param DWELL; ports clk, rst, clr, en, tick). It produces a one-cycle tick at count DWELL-1 and auto-reloads. The top level handles channel stepping and wrap.

Test Plan:
- Reset: rst=1 mid-scan at cur_ch=2 -> y=0, y_valid=0, cur_ch=0, wrap=0 asynchronously, before the next clk.
- Manual: WIDTH=8, CHANNELS=4, din={8'hDD,8'hCC,8'hBB,8'hAA}, enable=1, mode=0, sel=2 -> y=8'hCC, y_valid=1, cur_ch=2 one cycle later; sel changes to 0 -> y=8'hAA next cycle.
- Scan: DWELL=4, mode=1 for 20 cycles -> cur_ch sequence 0×4, 1×4, 2×4, 3×4, 0…; wrap high exactly at cycle 16 (first channel-0 cycle after 3); y matches the din slice each cycle.
- Disable: enable=0 during SCAN at cur_ch=1 -> y=0, y_valid=0 next cycle (with MUX_HOLD_EN: y holds 8'hBB); re-enable -> restart at channel 0.
- Mode switch: SCAN at cur_ch=3, dwell count 2, set mode=0 sel=1 -> y=8'hBB next cycle, wrap never pulses; mode=1 again -> cur_ch=0.
- Out-of-range: CHANNELS=3, manual sel=3 -> y=0, y_valid=0, cur_ch=3.
